cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Round-robin arbiter and sequencer that shares one iterative CORDIC instance (vectoring datapath, `enable`/`done` handshake) among `num_req` requesters. It accepts one operand triple at a time, holds the CORDIC `enable` asserted until `done`, and captures `xout`/`yout`. It returns the result to the owning requester on a valid/ready response channel. A watchdog aborts a transaction the core never completes and flags it as an error.

## Interface
- `data_width`, 16, width of x/y/z operands and results (matches the CORDIC core).
- `num_req`, 4, number of requesters (2..8).
- `timeout_cycles`, 64, maximum BUSY cycles before abort (>= core latency + 2).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  num_req  per-requester operand valid.
- `req_ready`  out  num_req  one-hot accept strobe.
- `req_x`, `req_y`, `req_z`  in  num_req*data_width  packed operands; requester i occupies bits [i*data_width +: data_width].
- `resp_valid`  out  num_req  one-hot result valid.
- `resp_ready`  in  num_req  per-requester result accept.
- `resp_x`, `resp_y`  out  data_width  shared result bus, meaningful when any `resp_valid` is set.
- `resp_error`  out  1  qualifies the current response as a timeout abort.
- `busy`  out  1  high in every state except IDLE.
- `cordic_enable`  out  1  drives the core `enable`.
- `cordic_clear`  out  1  one-cycle pulse; the integrator ORs it into the core `reset`.
- `cordic_xin`, `cordic_yin`, `cordic_zin`  out  data_width  registered operands to the core.
- `cordic_done`  in  1  core `done`.
- `cordic_xout`, `cordic_yout`  in  data_width  core results.

## Operation
- Reset values: state IDLE; pointer 0; all outputs 0, including operand and result registers.
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE**
  - Grant the first requester with `req_valid` high, searching from `pointer` upward modulo `num_req`.
  - Assert `req_ready[grant]` combinationally in the same cycle. At most one bit is set, and only in IDLE.
  - On that edge: latch `req_*[grant]` into `cordic_*in`, record `owner`=grant, set `pointer`=(grant+1) mod `num_req`, clear the watchdog, and go to BUSY.
  - With no `req_valid`: stay in IDLE, and `pointer` does not change.
- **BUSY**
  - `cordic_enable`=1 and the operands are held constant. The watchdog counts up each cycle.
  - When `cordic_done`=1 is sampled: latch `cordic_xout`/`cordic_yout` into `resp_x`/`resp_y`, set `resp_error`=0, and go to RESP. `cordic_enable` drops on that same edge.
  - When the watchdog reaches `timeout_cycles`-1 with no done: set `resp_x`=`resp_y`=0, set `resp_error`=1, pulse `cordic_clear` for the next cycle, and go to RESP.
  - If `done` and timeout coincide, `done` wins.
- **RESP**
  - `resp_valid[owner]`=1, and `resp_x`/`resp_y`/`resp_error` are stable.
  - On `resp_ready[owner]`=1: go to IDLE; `resp_valid` and `resp_error` clear on that edge.
  - `resp_ready` of non-owners is ignored.
  - `req_valid` changes during BUSY/RESP are ignored; requests are only sampled in IDLE.
- **Fairness**: a requester holding `req_valid` high is granted within `num_req` transactions.
- **Reset mid-operation**: everything returns to the reset values immediately. Any in-flight transaction is dropped with no response.

## Timing
- Accept edge T (`req_valid`&`req_ready`).
- `cordic_enable` is high from cycle T+1 until the edge that samples `cordic_done`.
- With core latency L, `done` is sampled at edge T+L and `resp_valid` rises in cycle T+L+1.
- The response lasts 1 cycle if `resp_ready` is already high.
- Throughput: one transaction per L+2 cycles; IDLE costs 1 cycle between transactions.
- Timeout: `resp_valid` rises `timeout_cycles`+1 cycles after acceptance, and `cordic_clear` is high in that same cycle.

## Test plan
- **Single requester**
  - Stimulus: `num_req`=4; requester 2 sends x=16'h2000, y=16'h2000, z=0; stub core with done after 16 cycles returns x=16'h2D41, y=0.
  - Required: `req_ready[2]` for 1 cycle; `cordic_enable` high for exactly 16 cycles; `resp_valid[2]` with 16'h2D41/0 and `resp_error`=0.
- **Round-robin**
  - Stimulus: all four `req_valid` held high continuously; `resp_ready` held high.
  - Required: grants 0,1,2,3,0 in order; the `resp_valid` owner matches each grant.
- **Response backpressure**
  - Stimulus: `resp_ready[1]` held low for 10 cycles.
  - Required: FSM stays in RESP with data stable; no new `req_ready` until the handshake completes.
- **Timeout**
  - Stimulus: `timeout_cycles`=8; stub core never asserts done.
  - Required: `resp_error`=1 and `resp_x`=`resp_y`=0 at cycle T+9; one `cordic_clear` pulse; next request accepted normally.
- **Done and timeout coincide**
  - Stimulus: `done` arrives on the timeout cycle.
  - Required: core result returned with `resp_error`=0; no `cordic_clear`.
- **Reset mid-BUSY**
  - Stimulus: assert `reset` asynchronously 5 cycles after accept.
  - Required: all outputs 0 without waiting for a clock edge; after release, requester 0 is granted first.

Source files
------------

// File: rtl/cordic_arbiter_if.sv
// Requester-side bundle for cordic_arbiter: per-requester operand channel and
// one-hot response channel sharing a single result bus.
interface cordic_arbiter_if #(
    parameter int data_width = 16,
    parameter int num_req    = 4
);
    logic [num_req-1:0]            req_valid;
    logic [num_req-1:0]            req_ready;
    logic [num_req*data_width-1:0] req_x;
    logic [num_req*data_width-1:0] req_y;
    logic [num_req*data_width-1:0] req_z;
    logic [num_req-1:0]            resp_valid;
    logic [num_req-1:0]            resp_ready;
    logic [data_width-1:0]         resp_x;
    logic [data_width-1:0]         resp_y;
    logic                          resp_error;

    modport master (
        output req_valid, req_x, req_y, req_z, resp_ready,
        input  req_ready, resp_valid, resp_x, resp_y, resp_error
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z, resp_ready,
        output req_ready, resp_valid, resp_x, resp_y, resp_error
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sequencer sharing one iterative CORDIC core among num_req
// requesters, with a watchdog that aborts transactions the core never finishes.
module cordic_arbiter #(
    parameter int data_width     = 16,
    parameter int num_req        = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    cordic_arbiter_if.slave              req_if,
    output logic                         busy,
    output logic                         cordic_enable,
    output logic                         cordic_clear,
    output logic signed [data_width-1:0] cordic_xin,
    output logic signed [data_width-1:0] cordic_yin,
    output logic signed [data_width-1:0] cordic_zin,
    input  logic                         cordic_done,
    input  logic signed [data_width-1:0] cordic_xout,
    input  logic signed [data_width-1:0] cordic_yout
);
    localparam int ptr_w = (num_req > 1) ? $clog2(num_req) : 1;
    localparam int wd_w  = $clog2(timeout_cycles) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state, state_nxt;
    logic [ptr_w-1:0]   pointer;
    logic [ptr_w-1:0]   owner;
    logic [ptr_w-1:0]   grant;
    logic               grant_vld;
    logic [ptr_w:0]     idx_sum;
    logic [wd_w-1:0]    wdog;
    logic               timeout_hit;
    logic [num_req-1:0] req_ready_c;
    logic [num_req-1:0] resp_valid_c;

    assign timeout_hit       = (wdog == wd_w'(timeout_cycles - 1));
    assign req_if.req_ready  = req_ready_c;
    assign req_if.resp_valid = resp_valid_c;

    // Scanning offsets from high to low leaves the closest requester at or after pointer.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx_sum   = '0;
        for (int i = num_req - 1; i >= 0; i--) begin
            idx_sum = {1'b0, pointer} + (ptr_w + 1)'(i);
            if (idx_sum >= (ptr_w + 1)'(num_req))
                idx_sum = idx_sum - (ptr_w + 1)'(num_req);
            if (req_if.req_valid[idx_sum[ptr_w-1:0]]) begin
                grant     = idx_sum[ptr_w-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready_c   = '0;
        resp_valid_c  = '0;
        busy          = (state != IDLE);
        cordic_enable = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    // Gated so every output reads zero while reset is held.
                    req_ready_c[grant] = ~reset;
                    state_nxt          = BUSY;
                end
            end
            BUSY: begin
                cordic_enable = 1'b1;
                if (cordic_done || timeout_hit)
                    state_nxt = RESP;
            end
            RESP: begin
                resp_valid_c[owner] = 1'b1;
                if (req_if.resp_ready[owner])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer           <= '0;
            owner             <= '0;
            wdog              <= '0;
            cordic_clear      <= 1'b0;
            cordic_xin        <= '0;
            cordic_yin        <= '0;
            cordic_zin        <= '0;
            req_if.resp_x     <= '0;
            req_if.resp_y     <= '0;
            req_if.resp_error <= 1'b0;
        end else begin
            cordic_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cordic_xin <= req_if.req_x[grant*data_width +: data_width];
                        cordic_yin <= req_if.req_y[grant*data_width +: data_width];
                        cordic_zin <= req_if.req_z[grant*data_width +: data_width];
                        owner      <= grant;
                        pointer    <= (grant == ptr_w'(num_req - 1)) ? '0 : grant + ptr_w'(1);
                        wdog       <= '0;
                    end
                end
                BUSY: begin
                    wdog <= wdog + wd_w'(1);
                    // A done on the timeout cycle still delivers the real result.
                    if (cordic_done) begin
                        req_if.resp_x     <= cordic_xout;
                        req_if.resp_y     <= cordic_yout;
                        req_if.resp_error <= 1'b0;
                    end else if (timeout_hit) begin
                        req_if.resp_x     <= '0;
                        req_if.resp_y     <= '0;
                        req_if.resp_error <= 1'b1;
                        cordic_clear      <= 1'b1;
                    end
                end
                RESP: begin
                    if (req_if.resp_ready[owner])
                        req_if.resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized bench for cordic_arbiter: stub CORDIC core with programmable latency
// and a transaction-level round-robin/timing model.
module tb_cordic_arbiter;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cordic_arbiter_if #(.data_width(DW), .num_req(NR)) bus();

    logic          busy, cordic_enable, cordic_clear, cordic_done;
    logic [DW-1:0] cordic_xin, cordic_yin, cordic_zin, cordic_xout, cordic_yout;

    cordic_arbiter #(.data_width(DW), .num_req(NR), .timeout_cycles(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_if        (bus.slave),
        .busy          (busy),
        .cordic_enable (cordic_enable),
        .cordic_clear  (cordic_clear),
        .cordic_xin    (cordic_xin),
        .cordic_yin    (cordic_yin),
        .cordic_zin    (cordic_zin),
        .cordic_done   (cordic_done),
        .cordic_xout   (cordic_xout),
        .cordic_yout   (cordic_yout)
    );

    // Stub core: done after lat enabled cycles, unless never_done.
    int            lat;
    bit            never_done;
    logic [DW-1:0] stub_x, stub_y;
    int            en_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            en_cnt <= 0;
        else if (!cordic_enable || cordic_clear)
            en_cnt <= 0;
        else
            en_cnt <= en_cnt + 1;
    end
    assign cordic_done = cordic_enable && !never_done && (en_cnt == lat - 1);
    assign cordic_xout = stub_x;
    assign cordic_yout = stub_y;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr     = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_x[i*DW +: DW] = DW'($urandom);
            bus.req_y[i*DW +: DW] = DW'($urandom);
            bus.req_z[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("idle_ready", bus.req_ready, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    // Called just after a negedge with the DUT in IDLE.
    task automatic do_txn(input logic [NR-1:0] vmask, input int lat_i, input bit nd,
                          input int bp, input logic [DW-1:0] sx, input logic [DW-1:0] sy);
        int g, n, resp_k, en_seen, clr_seen;
        bit got, tmo;
        logic [DW-1:0] ex, ey, ez, rx0, ry0;
        lat        = lat_i;
        never_done = nd;
        stub_x     = sx;
        stub_y     = sy;
        bus.req_valid = vmask;
        g   = pick(vmask);
        tmo = nd || (lat_i > TO);
        n   = tmo ? TO : lat_i;
        #1;
        check("grant", bus.req_ready, 64'd1 << g);
        ex = bus.req_x[g*DW +: DW];
        ey = bus.req_y[g*DW +: DW];
        ez = bus.req_z[g*DW +: DW];
        @(posedge clk);
        ptr = (g + 1) % NR;
        got = 0; resp_k = 0; en_seen = 0; clr_seen = 0;
        for (int k = 1; k <= TO + 3 && !got; k++) begin
            @(negedge clk);
            bus.req_valid = NR'($urandom);
            rand_ops();
            #1;
            check("busy_ready", bus.req_ready, 0);
            if (cordic_clear) clr_seen++;
            if (bus.resp_valid != 0) begin
                got = 1;
                resp_k = k;
            end else if (cordic_enable) begin
                en_seen++;
            end
        end
        check("resp_seen", got, 1);
        if (got) begin
            check("resp_lat", resp_k, n + 1);
            check("enable_cycles", en_seen, n);
            check("resp_owner", bus.resp_valid, 64'd1 << g);
            check("resp_x", bus.resp_x, tmo ? 0 : sx);
            check("resp_y", bus.resp_y, tmo ? 0 : sy);
            check("resp_error", bus.resp_error, tmo);
            check("clear_at_resp", cordic_clear, tmo);
            check("enable_off", cordic_enable, 0);
            check("xin_held", cordic_xin, ex);
            check("yin_held", cordic_yin, ey);
            check("zin_held", cordic_zin, ez);
            rx0 = bus.resp_x;
            ry0 = bus.resp_y;
            for (int b = 0; b < bp; b++) begin
                bus.resp_ready = NR'($urandom) & ~(NR'(1) << g);
                @(posedge clk);
                @(negedge clk);
                #1;
                if (cordic_clear) clr_seen++;
                check("bp_valid", bus.resp_valid, 64'd1 << g);
                check("bp_x", bus.resp_x, rx0);
                check("bp_y", bus.resp_y, ry0);
                check("bp_error", bus.resp_error, tmo);
                check("bp_ready", bus.req_ready, 0);
            end
            bus.resp_ready = NR'($urandom) | (NR'(1) << g);
            @(posedge clk);
            @(negedge clk);
            bus.req_valid  = '0;
            bus.resp_ready = '0;
            #1;
            check("resp_done", bus.resp_valid, 0);
            check("error_clr", bus.resp_error, 0);
            check("back_idle", busy, 0);
            check("clear_pulses", clr_seen, tmo);
        end
    endtask

    initial begin
        logic [NR-1:0] vm;
        int            r, li;
        bit            nd;
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        rand_ops();
        lat = 4; never_done = 0; stub_x = '0; stub_y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_enable", cordic_enable, 0);
        check("rst_clear", cordic_clear, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_x", bus.resp_x, 0);
        check("rst_xin", cordic_xin, 0);
        reset = 1'b0;
        ptr   = 0;
        idle(1);

        // Round-robin with every requester pending.
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            do_txn(4'hF, $urandom_range(1, 10), 0, 0, DW'($urandom), DW'($urandom));
        end

        // Single requester with known operands and result.
        rand_ops();
        bus.req_x[2*DW +: DW] = 16'h2000;
        bus.req_y[2*DW +: DW] = 16'h2000;
        bus.req_z[2*DW +: DW] = 16'h0000;
        do_txn(4'b0100, 16, 0, 0, 16'h2D41, 16'h0000);
        idle(3);

        // Backpressure, timeout, then boundary latencies.
        rand_ops();
        do_txn(4'b0010, 6, 0, 10, DW'($urandom), DW'($urandom));
        rand_ops();
        do_txn(4'b1001, 5, 1, 2, 16'hBEEF, 16'hCAFE);
        rand_ops();
        do_txn(4'b0100, 3, 0, 0, DW'($urandom), DW'($urandom));
        rand_ops();
        do_txn(4'hF, TO, 0, 0, 16'h1357, 16'h2468);
        rand_ops();
        do_txn(4'hF, TO - 1, 0, 1, DW'($urandom), DW'($urandom));

        for (int t = 0; t < 40; t++) begin
            vm = NR'($urandom_range(1, 15));
            r  = $urandom_range(0, 9);
            nd = (r == 0);
            li = (r == 1) ? TO : (r == 2) ? TO - 1 : $urandom_range(1, TO - 2);
            rand_ops();
            do_txn(vm, li, nd, $urandom_range(0, 3), DW'($urandom), DW'($urandom));
            idle($urandom_range(0, 2));
        end

        // Reset mid-BUSY: leave the pointer away from 0, then abort.
        rand_ops();
        do_txn(4'b0001, 4, 0, 0, 16'h1234, 16'h5678);
        lat = TO - 2; never_done = 0;
        bus.req_valid = 4'b0010;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_enable", cordic_enable, 0);
        check("mid_clear", cordic_clear, 0);
        check("mid_req_ready", bus.req_ready, 0);
        check("mid_resp_valid", bus.resp_valid, 0);
        check("mid_resp_x", bus.resp_x, 0);
        check("mid_resp_y", bus.resp_y, 0);
        check("mid_resp_error", bus.resp_error, 0);
        check("mid_xin", cordic_xin, 0);
        check("mid_yin", cordic_yin, 0);
        check("mid_zin", cordic_zin, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = '0;
        ptr = 0;
        idle(1);
        rand_ops();
        do_txn(4'hF, 7, 0, 0, DW'($urandom), DW'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
